code_onehot_decoder: RTL and testbench

CODE_ONEHOT_DECODER -- requirements
Module: code_onehot_decoder

---
 rtl/code_onehot_decoder.sv | 141 ++++++++++++++
 tb/tb_code_onehot_decoder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_onehot_decoder.sv
// code_onehot_decoder
// Accepts encoder code bytes through a 4-entry FIFO and replays each one as a
// 16-bit one-hot pattern held for a programmable number of cycles.
//
// Ports
//   clk, rst     : single clock; synchronous active-high reset
//   code_in      : 8'h00-8'h0F = index in [3:0], 8'hF0 = "no input active",
//                  anything else is invalid (consumed, flagged, dropped)
//   code_valid   : code_in is offered
//   code_ready   : block accepts code_in this cycle
//   hold_cycles  : cycles each pattern is driven (0 is treated as 1)
//   onehot_out   : registered decoded pattern
//   out_valid    : a decoded slot (including an idle 8'hF0 slot) is driven
//   err_pulse    : one-cycle flag, an invalid code was accepted last edge
//   fifo_count   : FIFO occupancy 0-4
//   state_dbg    : FSM state (0 = IDLE, 1 = HOLD)
//
// Handshake: a transfer happens on every rising edge where code_valid and
// code_ready are both high. code_ready depends only on rst and the registered
// occupancy, never on a same-cycle pop, so a full FIFO refuses a push even on
// the edge where it also pops.
module code_onehot_decoder #(
  parameter int HOLD_W = 8,
  parameter int DEPTH  = 4   // only 4 is supported
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        code_in,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic [15:0]       onehot_out,
  output logic              out_valid,
  output logic              err_pulse,
  output logic [2:0]        fifo_count,
  output logic              state_dbg
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state;

  // Entry layout: {is_none, index}; is_none marks the 8'hF0 idle code.
  logic [4:0]        mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic              code_is_idx;
  logic              code_is_none;
  logic              code_ok;
  logic              accept;
  logic              push;
  logic              pop;
  logic [4:0]        head;
  logic [HOLD_W-1:0] hold_load;

  assign code_is_idx  = (code_in[7:4] == 4'h0);
  assign code_is_none = (code_in == 8'hF0);
  assign code_ok      = code_is_idx | code_is_none;

  assign code_ready = !rst && (fifo_count < 3'(DEPTH));
  assign accept     = code_valid && code_ready;
  assign push       = accept && code_ok;

  // Pop whenever the current slot is finished (IDLE, or last HOLD cycle).
  assign pop  = (fifo_count != 3'd0) && ((state == IDLE) || (hold_cnt == '0));
  assign head = mem[rd_ptr];

  // Counter is loaded with H-1 so the pattern is visible for exactly H cycles.
  assign hold_load = (hold_cycles == '0) ? '0 : hold_cycles - 1'b1;

  assign state_dbg = (state == HOLD);

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {code_is_none, code_in[3:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= 3'd0;
      hold_cnt   <= '0;
      onehot_out <= 16'h0000;
      out_valid  <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      err_pulse <= accept && !code_ok;

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            onehot_out <= head[4] ? 16'h0000 : (16'h0001 << head[3:0]);
            out_valid  <= 1'b1;
            hold_cnt   <= hold_load;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else if (pop) begin
            // Back-to-back load, no gap cycle.
            onehot_out <= head[4] ? 16'h0000 : (16'h0001 << head[3:0]);
            out_valid  <= 1'b1;
            hold_cnt   <= hold_load;
          end else begin
            onehot_out <= 16'h0000;
            out_valid  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_onehot_decoder.sv
// Directed testbench for code_onehot_decoder.
module tb_code_onehot_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  code_in;
  logic        code_valid;
  logic        code_ready;
  logic [7:0]  hold_cycles;
  logic [15:0] onehot_out;
  logic        out_valid;
  logic        err_pulse;
  logic [2:0]  fifo_count;
  logic        state_dbg;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  code_onehot_decoder #(.HOLD_W(8), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .code_in     (code_in),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .hold_cycles (hold_cycles),
    .onehot_out  (onehot_out),
    .out_valid   (out_valid),
    .err_pulse   (err_pulse),
    .fifo_count  (fifo_count),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    code_valid = 1'b0;
    code_in    = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst         = 1'b1;
    code_valid  = 1'b0;
    code_in     = 8'h00;
    hold_cycles = 8'd1;
    tick();
    tick();
    checks++; if (onehot_out !== 16'h0000) begin errors++; $display("FAIL reset_onehot got %h exp 0000", onehot_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_pulse); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    checks++; if (code_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst got %b exp 0", code_ready); end
    checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL reset_state got %b exp 0", state_dbg); end
    rst = 1'b0;
    #1;
    checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b exp 1", code_ready); end
  endtask

  // hold=3, one code 8'h05 -> 16'h0020 for 3 cycles starting after T+1.
  task automatic test_single();
    do_reset();
    hold_cycles = 8'd3;
    code_in     = 8'h05;
    code_valid  = 1'b1;
    tick();  // edge T
    code_valid = 1'b0;
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count_T got %0d exp 1", fifo_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_T got %b exp 0", out_valid); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++; if (onehot_out !== 16'h0020 || out_valid !== 1'b1)
        begin errors++; $display("FAIL single_hold_%0d got %h/%b exp 0020/1", c, onehot_out, out_valid); end
    end
    tick();
    checks++; if (onehot_out !== 16'h0000 || out_valid !== 1'b0)
      begin errors++; $display("FAIL single_end got %h/%b exp 0000/0", onehot_out, out_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_count_end got %0d exp 0", fifo_count); end
  endtask

  // hold=1, 8'h0F, 8'hF0, 8'h00 back-to-back.
  task automatic test_back_to_back();
    logic [7:0]  codes [3] = '{8'h0F, 8'hF0, 8'h00};
    logic [15:0] exp_o [4] = '{16'h8000, 16'h0000, 16'h0001, 16'h0000};
    logic        exp_v [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    hold_cycles = 8'd1;
    code_valid  = 1'b1;
    code_in     = codes[0];
    tick();  // edge T
    for (int c = 0; c < 4; c++) begin
      if (c < 2) code_in = codes[c + 1];
      else code_valid = 1'b0;
      tick();
      checks++; if (onehot_out !== exp_o[c] || out_valid !== exp_v[c])
        begin errors++; $display("FAIL b2b_slot%0d got %h/%b exp %h/%b", c, onehot_out, out_valid, exp_o[c], exp_v[c]); end
    end
  endtask

  // hold=8, six codes pushed continuously; FIFO fills and back-pressures.
  task automatic test_fifo_full();
    logic [7:0]  codes [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    int          idx = 0;
    int          cyc = 0;
    logic        hs;
    logic        saw_full = 1'b0;
    logic        left_full = 1'b0;
    logic        prev_v = 1'b0;
    logic [15:0] prev_o = 16'h0000;
    logic [15:0] e;
    do_reset();
    hold_cycles = 8'd8;
    exp_q.delete();
    for (int k = 0; k < 6; k++) exp_q.push_back(16'h0001 << codes[k][3:0]);
    code_valid = 1'b1;
    code_in    = codes[0];
    while (cyc < 300 && !(exp_q.size() == 0 && !out_valid && idx == 6)) begin
      hs = code_valid && code_ready;
      tick();
      cyc++;
      if (hs) begin
        idx++;
        if (idx < 6) code_in = codes[idx];
        else code_valid = 1'b0;
      end
      if (fifo_count == 3'd4 && !saw_full) begin
        saw_full = 1'b1;
        checks++; if (code_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", code_ready); end
      end
      if (saw_full && !left_full && fifo_count != 3'd4) begin
        left_full = 1'b1;
        // The pop edge out of full must not have accepted the waiting code.
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL full_pop_count got %0d exp 3", fifo_count); end
        checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL full_ready_rise got %b exp 1", code_ready); end
      end
      if ($countones(onehot_out) > 1) begin
        checks++; errors++; $display("FAIL onehot_multi got %h exp at most one bit", onehot_out);
      end
      if (out_valid && (!prev_v || onehot_out != prev_o)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL fifo_extra got %h exp none", onehot_out);
        end else begin
          e = exp_q.pop_front();
          if (onehot_out !== e) begin errors++; $display("FAIL fifo_order got %h exp %h", onehot_out, e); end
        end
      end
      prev_v = out_valid;
      prev_o = onehot_out;
    end
    code_valid = 1'b0;
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL fifo_reached_full got %b exp 1", saw_full); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fifo_missing got %0d left exp 0", exp_q.size()); end
    checks++; if (idx != 6) begin errors++; $display("FAIL fifo_accepted got %0d exp 6", idx); end
  endtask

  // 8'h1A is consumed and flagged; only 8'h03 appears.
  task automatic test_invalid();
    do_reset();
    hold_cycles = 8'd1;
    code_valid  = 1'b1;
    code_in     = 8'h1A;
    tick();  // edge T
    code_in = 8'h03;
    checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL inv_err got %b exp 1", err_pulse); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL inv_count got %0d exp 0", fifo_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL inv_valid got %b exp 0", out_valid); end
    tick();  // edge T+1, 8'h03 accepted
    code_valid = 1'b0;
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL inv_err_clear got %b exp 0", err_pulse); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL inv_count_valid got %0d exp 1", fifo_count); end
    tick();
    checks++; if (onehot_out !== 16'h0008 || out_valid !== 1'b1)
      begin errors++; $display("FAIL inv_out got %h/%b exp 0008/1", onehot_out, out_valid); end
    tick();
    checks++; if (onehot_out !== 16'h0000 || out_valid !== 1'b0)
      begin errors++; $display("FAIL inv_end got %h/%b exp 0000/0", onehot_out, out_valid); end
  endtask

  // hold=0 acts as 1; hold changed 2->5 mid-pattern.
  task automatic test_hold();
    do_reset();
    hold_cycles = 8'd0;
    code_valid  = 1'b1;
    code_in     = 8'h07;
    tick();
    code_in = 8'h08;
    tick();
    code_valid = 1'b0;
    checks++; if (onehot_out !== 16'h0080 || out_valid !== 1'b1)
      begin errors++; $display("FAIL hold0_a got %h/%b exp 0080/1", onehot_out, out_valid); end
    tick();
    checks++; if (onehot_out !== 16'h0100 || out_valid !== 1'b1)
      begin errors++; $display("FAIL hold0_b got %h/%b exp 0100/1", onehot_out, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold0_end got %b exp 0", out_valid); end

    hold_cycles = 8'd2;
    code_valid  = 1'b1;
    code_in     = 8'h02;
    tick();  // T
    code_in = 8'h03;
    tick();  // T+1, 8'h02 loaded with hold 2
    code_valid  = 1'b0;
    hold_cycles = 8'd5;
    checks++; if (onehot_out !== 16'h0004) begin errors++; $display("FAIL hold2_c1 got %h exp 0004", onehot_out); end
    tick();
    checks++; if (onehot_out !== 16'h0004) begin errors++; $display("FAIL hold2_c2 got %h exp 0004", onehot_out); end
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++; if (onehot_out !== 16'h0008 || out_valid !== 1'b1)
        begin errors++; $display("FAIL hold5_c%0d got %h/%b exp 0008/1", c, onehot_out, out_valid); end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold5_end got %b exp 0", out_valid); end
  endtask

  // Reset mid-HOLD with three codes queued.
  task automatic test_reset_mid_hold();
    logic [7:0] codes [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_reset();
    hold_cycles = 8'd8;
    code_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      code_in = codes[k];
      tick();
    end
    code_valid = 1'b0;
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL rmid_count got %0d exp 3", fifo_count); end
    checks++; if (onehot_out !== 16'h0002 || out_valid !== 1'b1)
      begin errors++; $display("FAIL rmid_holding got %h/%b exp 0002/1", onehot_out, out_valid); end
    rst = 1'b1;
    tick();
    checks++; if (onehot_out !== 16'h0000 || out_valid !== 1'b0 || fifo_count !== 3'd0)
      begin errors++; $display("FAIL rmid_cleared got %h/%b/%0d exp 0000/0/0", onehot_out, out_valid, fifo_count); end
    checks++; if (code_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_rst got %b exp 0", code_ready); end
    rst = 1'b0;
    #1;
    checks++; if (code_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_after got %b exp 1", code_ready); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || onehot_out !== 16'h0000)
        begin errors++; $display("FAIL rmid_residual%0d got %h/%b exp 0000/0", c, onehot_out, out_valid); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst         = 1'b1;
    code_valid  = 1'b0;
    code_in     = 8'h00;
    hold_cycles = 8'd1;
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_invalid();
    test_hold();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
